// File: rtl/readout_dout_pkg.sv
// Purpose: shared widths and FSM state encoding for the readout Dout transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package readout_dout_pkg;

    localparam int WORD_W = 16;  // parallel word width
    localparam int GRAY_W = 12;  // low bits that are Gray-encoded on the wire
    localparam int NUM_W  = 12;  // words-per-frame / word counter width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } tx_state_t;

endpackage

// File: rtl/readout_dout_tx_bin_2_gray.sv
// Purpose: binary to Gray conversion of the low GRAY_W bits of a readout word.
// Latency: combinational.
// Backpressure: none.
// Ports: bin (binary in), gray (Gray-coded out).
module bin_2_gray
    import readout_dout_pkg::*;
(
    input  logic [GRAY_W-1:0] bin,
    output logic [GRAY_W-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/readout_dout_tx.sv
// Purpose: emulates the ASIC serial readout (TransmitOnb/Doutb): frames of In_Num_Words words, MSB first, active-low data.
// Latency: TransmitOnb falls one cycle after the accepted In_Start edge (IDLE -> LOAD -> SHIFT); outputs are registered.
// Backpressure: source-paced; Ready pulses once per word, a missing Valid at that cycle inserts PAD_WORD and sets Underflow.
//
// Build option: DOUT_TX_GRAY_EN defined -> bits [11:0] are Gray-encoded on the wire;
//               undefined -> words go out raw (debug of the receiver bit path).
// Ports:
//   Clk, Rst_N                    clock, asynchronous active-low reset
//   In_Start, In_Num_Words        frame request and its length (sampled in IDLE)
//   In_Data, In_Data_Valid        parallel binary word from the source
//   Out_Data_Ready                word consumed on Valid & Ready
//   Out_Doutb, Out_TransmitOnb    serial wire, both idle high
//   Out_Busy, Out_Underflow       status; Underflow is sticky until next accepted start
//   Out_Word_Cnt                  words fully shifted in the current/last frame
module readout_dout_tx
    import readout_dout_pkg::*;
#(
    parameter int                DIV_RATIO  = 4,
    parameter int                GAP_CYCLES = 16,
    parameter logic [WORD_W-1:0] PAD_WORD   = 16'h0000
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic              In_Start,
    input  logic [NUM_W-1:0]  In_Num_Words,
    input  logic [WORD_W-1:0] In_Data,
    input  logic              In_Data_Valid,
    output logic              Out_Data_Ready,
    output logic              Out_Doutb,
    output logic              Out_TransmitOnb,
    output logic              Out_Busy,
    output logic              Out_Underflow,
    output logic [NUM_W-1:0]  Out_Word_Cnt
);

    localparam int DIV_W = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATIO - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV_RATIO - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    tx_state_t         state_q, state_d;
    logic [WORD_W-1:0] tx_word_q, tx_word_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [NUM_W-1:0]  num_words_q, num_words_d;
    logic [NUM_W-1:0]  word_cnt_q, word_cnt_d;
    logic              underflow_q, underflow_d;
    logic              doutb_q, doutb_d;
    logic              tob_q, tob_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    // Word that would be captured this cycle: source data or pad, then line-encoded.
    logic [WORD_W-1:0] src_word;
    logic [WORD_W-1:0] enc_word;

    assign src_word = In_Data_Valid ? In_Data : PAD_WORD;

`ifdef DOUT_TX_GRAY_EN
    logic [GRAY_W-1:0] gray_lo;

    bin_2_gray u_bin_2_gray (
        .bin  (src_word[GRAY_W-1:0]),
        .gray (gray_lo)
    );

    assign enc_word = {src_word[WORD_W-1:GRAY_W], gray_lo};
`else
    assign enc_word = src_word;
`endif

    // One extra bit so the "another word follows" compare cannot wrap at 12'hFFF.
    logic [NUM_W:0] word_cnt_inc;
    logic           more_words;

    assign word_cnt_inc = {1'b0, word_cnt_q} + (NUM_W+1)'(1);
    assign more_words   = word_cnt_inc < {1'b0, num_words_q};

    always_comb begin
        state_d     = state_q;
        tx_word_d   = tx_word_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        num_words_d = num_words_q;
        word_cnt_d  = word_cnt_q;
        underflow_d = underflow_q;
        doutb_d     = doutb_q;
        tob_d       = tob_q;
        ready_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (In_Start && (In_Num_Words != '0)) begin
                    num_words_d = In_Num_Words;
                    word_cnt_d  = '0;
                    underflow_d = 1'b0;
                    ready_d     = 1'b1;  // Ready is high for the whole LOAD cycle
                    state_d     = LOAD;
                end
            end

            LOAD: begin
                tx_word_d = enc_word;
                if (!In_Data_Valid) underflow_d = 1'b1;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                tob_d     = 1'b0;
                doutb_d   = ~enc_word[WORD_W-1];
                state_d   = SHIFT;
            end

            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;  // wraps 15 -> 0 at word end
                    if (bit_cnt_q == 4'hF) begin
                        word_cnt_d = (word_cnt_q == {NUM_W{1'b1}}) ? word_cnt_q
                                                                   : word_cnt_q + NUM_W'(1);
                        if (more_words) begin
                            // The prefetched word goes straight onto the wire: no idle bit.
                            tx_word_d = enc_word;
                            if (!In_Data_Valid) underflow_d = 1'b1;
                            doutb_d   = ~enc_word[WORD_W-1];
                        end else begin
                            tob_d     = 1'b1;
                            doutb_d   = 1'b1;
                            gap_cnt_d = '0;
                            state_d   = GAP;
                        end
                    end else begin
                        doutb_d = ~tx_word_q[4'd14 - bit_cnt_q];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                    // Registered Ready lands on the last Clk cycle of the word's final bit.
                    if ((bit_cnt_q == 4'hF) && (div_cnt_q == DIV_PRE) && more_words)
                        ready_d = 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                tob_d   = 1'b1;
                doutb_d = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q     <= IDLE;
            tx_word_q   <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            num_words_q <= '0;
            word_cnt_q  <= '0;
            underflow_q <= 1'b0;
            doutb_q     <= 1'b1;
            tob_q       <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_word_q   <= tx_word_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            num_words_q <= num_words_d;
            word_cnt_q  <= word_cnt_d;
            underflow_q <= underflow_d;
            doutb_q     <= doutb_d;
            tob_q       <= tob_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign Out_Data_Ready  = ready_q;
    assign Out_Doutb       = doutb_q;
    assign Out_TransmitOnb = tob_q;
    assign Out_Busy        = busy_q;
    assign Out_Underflow   = underflow_q;
    assign Out_Word_Cnt    = word_cnt_q;

endmodule

// File: tb/tb_readout_dout_tx.sv
// Purpose: directed self-checking bench for readout_dout_tx (framing, serial bits, prefetch, pad, gap, reset).
// Latency: n/a.
// Backpressure: the bench source presents the next word right after each consumption.
module tb_readout_dout_tx;

    localparam int DIV = 4;
    localparam int GAP = 16;

`ifdef DOUT_TX_GRAY_EN
    localparam bit GRAY = 1'b1;
`else
    localparam bit GRAY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_start;
    logic [11:0] in_num_words;
    logic [15:0] in_data;
    logic        in_data_valid;
    logic        ready;
    logic        doutb;
    logic        tob;
    logic        busy;
    logic        underflow;
    logic [11:0] word_cnt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] src      [0:63];
    logic [15:0] exp_wire [0:63];

    always #5 clk = ~clk;

    readout_dout_tx #(
        .DIV_RATIO  (DIV),
        .GAP_CYCLES (GAP),
        .PAD_WORD   (16'h0000)
    ) dut (
        .Clk             (clk),
        .Rst_N           (rst_n),
        .In_Start        (in_start),
        .In_Num_Words    (in_num_words),
        .In_Data         (in_data),
        .In_Data_Valid   (in_data_valid),
        .Out_Data_Ready  (ready),
        .Out_Doutb       (doutb),
        .Out_TransmitOnb (tob),
        .Out_Busy        (busy),
        .Out_Underflow   (underflow),
        .Out_Word_Cnt    (word_cnt)
    );

    // Line encoding the receiver expects for a binary word.
    function automatic logic [15:0] enc(input logic [15:0] b);
        if (GRAY) return {b[15:12], b[11:0] ^ {1'b0, b[11:1]}};
        return b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a frame and plays the source/receiver side until TransmitOnb returns high.
    // mid_start: low-cycle index at which a stray In_Start is pulsed (-1 = none).
    // abort_at:  low-cycle index at which reset is asserted (-1 = none).
    task automatic run_frame(input string tag, input int num, input int nvalid,
                             input int mid_start, input int abort_at);
        int          idx       = 0;
        int          ready_cnt = 0;
        int          low_cnt   = 0;
        int          cyc       = 0;
        int          w;
        int          b;
        bit          pend      = 1'b0;
        bit          seen_low  = 1'b0;
        bit          done      = 1'b0;
        bit          glitch    = 1'b0;
        bit          aborted   = 1'b0;
        logic [15:0] cap [0:63];

        in_num_words  = 12'(num);
        in_data       = src[0];
        in_data_valid = (nvalid > 0);
        in_start      = 1'b1;
        while (!done && !aborted && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            in_start = 1'b0;
            if (pend) idx++;
            in_data       = src[idx % 64];
            in_data_valid = (idx < nvalid);
            if (ready === 1'b1) ready_cnt++;
            pend = (ready === 1'b1) && in_data_valid;
            if (tob === 1'b0) begin
                seen_low = 1'b1;
                w = low_cnt / (16 * DIV);
                b = 15 - ((low_cnt / DIV) % 16);
                if (w < 64) begin
                    if ((low_cnt % DIV) == 0) cap[w][b] = ~doutb;
                    else if (cap[w][b] !== ~doutb) glitch = 1'b1;
                end
                low_cnt++;
                if (low_cnt == mid_start) in_start = 1'b1;
                if (low_cnt == abort_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check({tag, "_rst_doutb"}, 32'(doutb), 32'd1);
                    check({tag, "_rst_tob"},   32'(tob),   32'd1);
                    check({tag, "_rst_busy"},  32'(busy),  32'd0);
                    check({tag, "_rst_ready"}, 32'(ready), 32'd0);
                    check({tag, "_rst_wcnt"},  32'(word_cnt), 32'd0);
                    in_data_valid = 1'b0;
                    @(posedge clk); #1;
                    rst_n   = 1'b1;
                    aborted = 1'b1;
                end
            end else if (seen_low) begin
                done = 1'b1;
            end
        end

        if (!aborted) begin
            check({tag, "_done"},   32'(done),      32'd1);
            check({tag, "_lowlen"}, 32'(low_cnt),   32'(num * 16 * DIV));
            check({tag, "_readys"}, 32'(ready_cnt), 32'(num));
            check({tag, "_stable"}, 32'(glitch),    32'd0);
            for (int i = 0; i < num && i < 64; i++)
                check($sformatf("%s_word%0d", tag, i), 32'(cap[i]), 32'(exp_wire[i]));
            check({tag, "_wcnt"},     32'(word_cnt), 32'(num));
            check({tag, "_gapdoutb"}, 32'(doutb),    32'd1);
            check({tag, "_gapbusy"},  32'(busy),     32'd1);
        end
    endtask

    // Waits out the gap, optionally pulsing In_Start on its first cycle.
    task automatic wait_idle(input string tag, input logic start_pulse);
        int n     = 0;
        bit hi_ok = 1'b1;
        in_start = start_pulse;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            in_start = 1'b0;
            n++;
            if (tob !== 1'b1) hi_ok = 1'b0;
        end
        in_start = 1'b0;
        check({tag, "_gaplen"},  32'(n),     32'(GAP));
        check({tag, "_gaphigh"}, 32'(hi_ok), 32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        in_start      = 1'b0;
        in_num_words  = '0;
        in_data       = '0;
        in_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_doutb", 32'(doutb),     32'd1);
        check("reset_tob",   32'(tob),       32'd1);
        check("reset_ready", 32'(ready),     32'd0);
        check("reset_busy",  32'(busy),      32'd0);
        check("reset_uflow", 32'(underflow), 32'd0);
        check("reset_wcnt",  32'(word_cnt),  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word: 0x35A5 -> 0x3777 Gray-encoded.
        src[0]      = 16'h35A5;
        exp_wire[0] = GRAY ? 16'h3777 : 16'h35A5;
        run_frame("t1", 1, 1, -1, -1);
        wait_idle("t1", 1'b0);

        // Three back-to-back words.
        src[0] = 16'h0001; src[1] = 16'h0FFF; src[2] = 16'hF000;
        exp_wire[0] = 16'h0001;
        exp_wire[1] = GRAY ? 16'h0800 : 16'h0FFF;
        exp_wire[2] = 16'hF000;
        run_frame("t2", 3, 3, -1, -1);
        check("t2_uflow", 32'(underflow), 32'd0);
        wait_idle("t2", 1'b0);

        // Source runs dry before the second prefetch -> pad word.
        src[0] = 16'hA5C3; src[1] = 16'hFFFF;
        exp_wire[0] = GRAY ? 16'hA722 : 16'hA5C3;
        exp_wire[1] = 16'h0000;
        run_frame("t3", 2, 1, -1, -1);
        check("t3_uflow", 32'(underflow), 32'd1);
        wait_idle("t3", 1'b0);
        check("t3_uflow_hold", 32'(underflow), 32'd1);

        // Start with zero words is ignored.
        in_num_words = 12'd0;
        in_start     = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        check("t4_zero_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_zero_tob",   32'(tob),   32'd1);
        check("t4_zero_ready", 32'(ready), 32'd0);

        // Stray starts mid-frame and during the gap are dropped; accepted start clears Underflow.
        src[0] = 16'h0123; src[1] = 16'h8421;
        exp_wire[0] = enc(16'h0123);
        exp_wire[1] = enc(16'h8421);
        run_frame("t4", 2, 2, 40, -1);
        check("t4_uflow_clr", 32'(underflow), 32'd0);
        wait_idle("t4", 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t4_gapstart_busy", 32'(busy), 32'd0);
        check("t4_gapstart_tob",  32'(tob),  32'd1);

        // Reset at bit 7 of the second word, then a clean frame.
        src[0] = 16'hFFFF; src[1] = 16'h5555;
        run_frame("t5a", 2, 2, -1, 16 * DIV + 7 * DIV + 1);
        repeat (2) @(posedge clk);
        #1;
        check("t5_post_busy", 32'(busy), 32'd0);
        src[0]      = 16'h1234;
        exp_wire[0] = GRAY ? 16'h132E : 16'h1234;
        run_frame("t5b", 1, 1, -1, -1);
        wait_idle("t5b", 1'b0);

        // Longer random frame.
        for (int i = 0; i < 40; i++) begin
            src[i]      = 16'($urandom);
            exp_wire[i] = enc(src[i]);
        end
        run_frame("t6", 40, 40, -1, -1);
        wait_idle("t6", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
